fpu_8_scheduler: RTL and testbench

Sequencer and two-port arbiter that shares one 8-bit FPU core between two requesters. It accepts operations over per-port valid/ready handshakes and drives the core's start, operand, operation and rounding inputs from internal registers. It holds each operation for a fixed number of cycles, captures the result and exception outputs, and returns them on the owning port's response handshake. It sits between the instruction/issue logic and the FPU core.

---
 rtl/fpu_8_pkg.sv | 45 ++++
 rtl/fpu_8_rr_arbiter.sv | 50 +++++
 rtl/fpu_8_scheduler.sv | 151 +++++++++++++++
 tb/tb_fpu_8_scheduler.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_8_pkg.sv
// Shared types and widths for the 8-bit FPU scheduler and its arbiter.
package fpu_8_pkg;

    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned OP_W    = 2;
    localparam int unsigned EXC_W   = 2;
    localparam int unsigned CNT_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic [DATA_W-1:0] op_a;
        logic [DATA_W-1:0] op_b;
        logic [OP_W-1:0]   operation;
        logic              round_mode;
    } fpu_req_t;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic              is_exception;
        logic [EXC_W-1:0]  exception;
    } fpu_rsp_t;

    // Extract one requester's operation fields from the concatenated request buses.
    function automatic fpu_req_t pick_req(
        input logic                        sel,
        input logic [NUM_REQ*DATA_W-1:0]   op_a,
        input logic [NUM_REQ*DATA_W-1:0]   op_b,
        input logic [NUM_REQ*OP_W-1:0]     operation,
        input logic [NUM_REQ-1:0]          round_mode
    );
        fpu_req_t r;
        r.op_a       = sel ? op_a[2*DATA_W-1:DATA_W]    : op_a[DATA_W-1:0];
        r.op_b       = sel ? op_b[2*DATA_W-1:DATA_W]    : op_b[DATA_W-1:0];
        r.operation  = sel ? operation[2*OP_W-1:OP_W]   : operation[OP_W-1:0];
        r.round_mode = round_mode[sel];
        return r;
    endfunction

endpackage

// File: rtl/fpu_8_rr_arbiter.sv
// Two-requester arbiter producing a one-hot grant.
// FPU_8_ARB_RR_EN selects round-robin; otherwise requester 0 has fixed priority.
module fpu_8_rr_arbiter
    import fpu_8_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               accept_i,
    output logic [NUM_REQ-1:0] grant_c_o
);

`ifdef FPU_8_ARB_RR_EN
    logic last_q;
    logic last_d;

    // On contention favour the requester that was not granted last.
    always_comb begin
        grant_c_o = req_i;
        if (req_i == 2'b11) begin
            grant_c_o = last_q ? 2'b01 : 2'b10;
        end
    end

    always_comb begin
        last_d = last_q;
        if (accept_i) begin
            last_d = grant_c_o[1];
        end
    end

    // Reset to "last = 1" so requester 0 wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    logic unused_arb;

    always_comb begin
        grant_c_o = req_i[0] ? 2'b01 : req_i;
    end

    assign unused_arb = ^{clk, rst_n, accept_i};
`endif

endmodule

// File: rtl/fpu_8_scheduler.sv
// Shares one 8-bit FPU core between two requesters: accept, hold for FPU_LAT cycles, respond.
// Arbitration policy selected by FPU_8_ARB_RR_EN (round-robin when defined, fixed priority otherwise).
module fpu_8_scheduler
    import fpu_8_pkg::*;
#(
    parameter int unsigned FPU_LAT = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    input  logic [NUM_REQ*DATA_W-1:0] req_op_a_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_op_b_i,
    input  logic [NUM_REQ*OP_W-1:0]   req_operation_i,
    input  logic [NUM_REQ-1:0]        req_round_mode_i,
    output logic [NUM_REQ-1:0]        rsp_valid_o,
    input  logic [NUM_REQ-1:0]        rsp_ready_i,
    output logic [DATA_W-1:0]         rsp_result_o,
    output logic                      rsp_is_exception_o,
    output logic [EXC_W-1:0]          rsp_exception_o,
    output logic                      fpu_start_o,
    output logic [DATA_W-1:0]         fpu_op_a_o,
    output logic [DATA_W-1:0]         fpu_op_b_o,
    output logic [OP_W-1:0]           fpu_operation_o,
    output logic                      fpu_round_mode_o,
    input  logic [DATA_W-1:0]         fpu_result_i,
    input  logic                      fpu_is_exception_i,
    input  logic [EXC_W-1:0]          fpu_exception_i,
    output logic                      busy_o
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FPU_LAT - 1);

    state_e             state_q;
    state_e             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               owner_q;
    logic               owner_d;
    logic               start_q;
    logic               start_d;
    fpu_req_t           fpu_q;
    fpu_req_t           fpu_d;
    fpu_rsp_t           rsp_q;
    fpu_rsp_t           rsp_d;

    logic [NUM_REQ-1:0] grant;
    logic               accept;
    logic               capture;

    fpu_8_rr_arbiter u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (req_valid_i),
        .accept_i  (accept),
        .grant_c_o (grant)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (|req_valid_i)            state_d = ST_EXEC;
            ST_EXEC: if (cnt_q == '0)             state_d = ST_RESP;
            ST_RESP: if (rsp_ready_i[owner_q])    state_d = ST_IDLE;
            default:                              state_d = ST_IDLE;
        endcase
    end

    // FSM outputs; ready is masked during reset so every output reads 0 while rst_n is low.
    always_comb begin
        req_ready_o = '0;
        rsp_valid_o = '0;
        busy_o      = 1'b0;
        accept      = 1'b0;
        capture     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready_o = grant & {NUM_REQ{rst_n}};
                accept      = |req_valid_i;
            end
            ST_EXEC: begin
                busy_o  = 1'b1;
                capture = (cnt_q == '0);
            end
            ST_RESP: begin
                busy_o      = 1'b1;
                rsp_valid_o = NUM_REQ'(1) << owner_q;
            end
            default: ;
        endcase
    end

    // Datapath next values: latch the winner's operation, count down, capture the core result.
    always_comb begin
        cnt_d   = cnt_q;
        owner_d = owner_q;
        start_d = 1'b0;
        fpu_d   = fpu_q;
        rsp_d   = rsp_q;
        if (accept) begin
            owner_d = grant[1];
            fpu_d   = pick_req(grant[1], req_op_a_i, req_op_b_i,
                               req_operation_i, req_round_mode_i);
            cnt_d   = CNT_LOAD;
            start_d = 1'b1;
        end else if ((state_q == ST_EXEC) && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        if (capture) begin
            rsp_d.result       = fpu_result_i;
            rsp_d.is_exception = fpu_is_exception_i;
            rsp_d.exception    = fpu_exception_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            owner_q <= 1'b0;
            start_q <= 1'b0;
            fpu_q   <= '0;
            rsp_q   <= '0;
        end else begin
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            start_q <= start_d;
            fpu_q   <= fpu_d;
            rsp_q   <= rsp_d;
        end
    end

    assign fpu_start_o        = start_q;
    assign fpu_op_a_o         = fpu_q.op_a;
    assign fpu_op_b_o         = fpu_q.op_b;
    assign fpu_operation_o    = fpu_q.operation;
    assign fpu_round_mode_o   = fpu_q.round_mode;
    assign rsp_result_o       = rsp_q.result;
    assign rsp_is_exception_o = rsp_q.is_exception;
    assign rsp_exception_o    = rsp_q.exception;

endmodule

// File: tb/tb_fpu_8_scheduler.sv
// Bench for fpu_8_scheduler: two instances (FPU_LAT 1 and 5) driven with directed and random operations.
// Expected grants follow FPU_8_ARB_RR_EN exactly as the RTL build does.
module tb_fpu_8_scheduler;

    localparam int unsigned LAT0 = 1;
    localparam int unsigned LAT1 = 5;

    logic clk;
    logic rst_n;

    logic [1:0]  req_valid  [2];
    logic [1:0]  req_ready  [2];
    logic [15:0] req_op_a   [2];
    logic [15:0] req_op_b   [2];
    logic [3:0]  req_oper   [2];
    logic [1:0]  req_rm     [2];
    logic [1:0]  rsp_valid  [2];
    logic [1:0]  rsp_ready  [2];
    logic [7:0]  rsp_result [2];
    logic        rsp_isx    [2];
    logic [1:0]  rsp_exc    [2];
    logic        fpu_start  [2];
    logic [7:0]  fpu_a      [2];
    logic [7:0]  fpu_b      [2];
    logic [1:0]  fpu_op     [2];
    logic        fpu_rm     [2];
    logic [7:0]  fpu_res    [2];
    logic        fpu_isx    [2];
    logic [1:0]  fpu_exc    [2];
    logic        busy       [2];

    logic        stub_fix;
    logic [7:0]  fix_res;
    logic        fix_isx;
    logic [1:0]  fix_exc;

    int          checks;
    int          fails;
    bit          last_m [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_inst
        // Core stub: a simple function of the registered core inputs, or a forced value.
        assign fpu_res[g] = stub_fix ? fix_res : 8'(fpu_a[g] + fpu_b[g] + {5'd0, fpu_op[g], fpu_rm[g]});
        assign fpu_isx[g] = stub_fix ? fix_isx : (fpu_a[g][7] ^ fpu_b[g][0]);
        assign fpu_exc[g] = stub_fix ? fix_exc : (fpu_a[g][1:0] ^ fpu_b[g][7:6]);

        fpu_8_scheduler #(.FPU_LAT(g == 0 ? LAT0 : LAT1)) u_dut (
            .clk                (clk),
            .rst_n              (rst_n),
            .req_valid_i        (req_valid[g]),
            .req_ready_o        (req_ready[g]),
            .req_op_a_i         (req_op_a[g]),
            .req_op_b_i         (req_op_b[g]),
            .req_operation_i    (req_oper[g]),
            .req_round_mode_i   (req_rm[g]),
            .rsp_valid_o        (rsp_valid[g]),
            .rsp_ready_i        (rsp_ready[g]),
            .rsp_result_o       (rsp_result[g]),
            .rsp_is_exception_o (rsp_isx[g]),
            .rsp_exception_o    (rsp_exc[g]),
            .fpu_start_o        (fpu_start[g]),
            .fpu_op_a_o         (fpu_a[g]),
            .fpu_op_b_o         (fpu_b[g]),
            .fpu_operation_o    (fpu_op[g]),
            .fpu_round_mode_o   (fpu_rm[g]),
            .fpu_result_i       (fpu_res[g]),
            .fpu_is_exception_i (fpu_isx[g]),
            .fpu_exception_i    (fpu_exc[g]),
            .busy_o             (busy[g])
        );
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Arbitration rule: single requester wins; on contention RR picks the one not granted last.
    function automatic int exp_grant(input logic [1:0] v, input bit last);
`ifdef FPU_8_ARB_RR_EN
        if (v == 2'b11) return last ? 0 : 1;
`endif
        return v[0] ? 0 : 1;
    endfunction

    function automatic int lat_of(input int k);
        return (k == 0) ? int'(LAT0) : int'(LAT1);
    endfunction

    task automatic rand_ops(input int k);
        req_op_a[k] = 16'($urandom);
        req_op_b[k] = 16'($urandom);
        req_oper[k] = 4'($urandom);
        req_rm[k]   = 2'($urandom);
    endtask

    task automatic outputs_zero(input int k, input string tag);
        check({tag, "_req_ready"}, 16'(req_ready[k]), 16'(0));
        check({tag, "_rsp_valid"}, 16'(rsp_valid[k]), 16'(0));
        check({tag, "_rsp_result"}, 16'(rsp_result[k]), 16'(0));
        check({tag, "_rsp_isx"}, 16'(rsp_isx[k]), 16'(0));
        check({tag, "_rsp_exc"}, 16'(rsp_exc[k]), 16'(0));
        check({tag, "_fpu_start"}, 16'(fpu_start[k]), 16'(0));
        check({tag, "_fpu_ctl"}, {fpu_a[k], fpu_b[k]}, 16'(0));
        check({tag, "_fpu_op_rm"}, 16'({fpu_op[k], fpu_rm[k]}), 16'(0));
        check({tag, "_busy"}, 16'(busy[k]), 16'(0));
    endtask

    task automatic idle_check(input int k, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle_rsp_valid", 16'(rsp_valid[k]), 16'(0));
            check("idle_busy", 16'(busy[k]), 16'(0));
        end
    endtask

    // One full transaction on instance k; obs_g is the grant index seen on req_ready.
    task automatic do_op(input int k, input logic [1:0] vmask, input int stall,
                         input bit pulse, output int obs_g);
        int         g;
        int         lat;
        logic [1:0] gm;
        logic [7:0] a, b, er;
        logic [1:0] op, ee;
        logic       rm, ex;

        lat = lat_of(k);
        @(negedge clk);
        req_valid[k] = vmask;
        rsp_ready[k] = 2'b00;
        g  = exp_grant(vmask, last_m[k]);
        gm = 2'(1 << g);
        a  = req_op_a[k][g*8 +: 8];
        b  = req_op_b[k][g*8 +: 8];
        op = req_oper[k][g*2 +: 2];
        rm = req_rm[k][g];
        er = stub_fix ? fix_res : 8'(a + b + {5'd0, op, rm});
        ex = stub_fix ? fix_isx : (a[7] ^ b[0]);
        ee = stub_fix ? fix_exc : (a[1:0] ^ b[7:6]);
        #1;
        check("req_ready_grant", 16'(req_ready[k]), 16'(gm));
        check("busy_idle", 16'(busy[k]), 16'(0));
        obs_g = req_ready[k][1] ? 1 : 0;

        @(posedge clk); #1;
        last_m[k]    = (g == 1);
        req_valid[k] = 2'b00;
        @(negedge clk);
        check("fpu_start_first", 16'(fpu_start[k]), 16'(1));
        check("fpu_operands", {fpu_a[k], fpu_b[k]}, {a, b});
        check("fpu_op_rm", 16'({fpu_op[k], fpu_rm[k]}), 16'({op, rm}));
        check("busy_exec", 16'(busy[k]), 16'(1));
        check("rsp_valid_exec", 16'(rsp_valid[k]), 16'(0));

        for (int c = 2; c <= lat; c++) begin
            @(posedge clk); #1;
            req_valid[k] = (pulse && c == 2) ? 2'b10 : 2'b00;
            @(negedge clk);
            check("fpu_start_later", 16'(fpu_start[k]), 16'(0));
            check("rsp_valid_exec", 16'(rsp_valid[k]), 16'(0));
            check("req_ready_exec", 16'(req_ready[k]), 16'(0));
        end

        @(posedge clk); #1;
        req_valid[k] = (stall > 0) ? 2'b11 : 2'b00;
        rsp_ready[k] = (stall > 0) ? ~gm : gm;
        @(negedge clk);
        check("rsp_valid_owner", 16'(rsp_valid[k]), 16'(gm));
        check("rsp_result", 16'(rsp_result[k]), 16'(er));
        check("rsp_exc", 16'({rsp_isx[k], rsp_exc[k]}), 16'({ex, ee}));
        check("req_ready_resp", 16'(req_ready[k]), 16'(0));

        for (int s = 1; s <= stall; s++) begin
            @(posedge clk); #1;
            req_valid[k] = (s == stall) ? 2'b00 : 2'b11;
            rsp_ready[k] = (s == stall) ? gm : ~gm;
            @(negedge clk);
            check("stall_rsp_valid", 16'(rsp_valid[k]), 16'(gm));
            check("stall_rsp_result", 16'(rsp_result[k]), 16'(er));
            check("stall_req_ready", 16'(req_ready[k]), 16'(0));
            check("stall_busy", 16'(busy[k]), 16'(1));
        end

        @(posedge clk); #1;
        rsp_ready[k] = 2'b00;
        req_valid[k] = 2'b00;
        @(negedge clk);
        check("back_to_idle", 16'(busy[k]), 16'(0));
        check("rsp_valid_done", 16'(rsp_valid[k]), 16'(0));
    endtask

    initial begin
        int       g;
        int       lat;
        logic [3:0] seq;

        checks   = 0;
        fails    = 0;
        stub_fix = 1'b0;
        fix_res  = 8'h00;
        fix_isx  = 1'b0;
        fix_exc  = 2'b00;
        rst_n    = 1'b0;
        for (int k = 0; k < 2; k++) begin
            req_valid[k] = 2'b00;
            rsp_ready[k] = 2'b00;
            last_m[k]    = 1'b1;
            rand_ops(k);
        end

        #12;
        outputs_zero(0, "reset0");
        outputs_zero(1, "reset1");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed single operation on the FPU_LAT=1 instance with a forced core result.
        req_op_a[0] = 16'h003C;
        req_op_b[0] = 16'h0040;
        req_oper[0] = 4'h0;
        req_rm[0]   = 2'b00;
        stub_fix    = 1'b1;
        fix_res     = 8'h44;
        do_op(0, 2'b01, 0, 1'b0, g);
        stub_fix    = 1'b0;

        // Four contended operations on a fresh pointer.
        seq = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            rand_ops(1);
            do_op(1, 2'b11, 0, 1'b0, g);
            seq[i] = g[0];
        end
`ifdef FPU_8_ARB_RR_EN
        check("grant_sequence", 16'(seq), 16'(4'b1010));
`else
        check("grant_sequence", 16'(seq), 16'(4'b0000));
`endif

        // Long response backpressure.
        rand_ops(1);
        do_op(1, 2'b01, 10, 1'b0, g);

        // Exception fields pass through to the owning port.
        rand_ops(1);
        stub_fix = 1'b1;
        fix_res  = 8'($urandom);
        fix_isx  = 1'b1;
        fix_exc  = 2'b10;
        do_op(1, 2'b10, 1, 1'b0, g);
        stub_fix = 1'b0;
        fix_isx  = 1'b0;
        fix_exc  = 2'b00;

        // Requester 1 pulses valid during EXEC: never served.
        rand_ops(1);
        do_op(1, 2'b01, 0, 1'b1, g);
        idle_check(1, 8);

        // Reset during the third EXEC cycle abandons the operation.
        rand_ops(1);
        lat = lat_of(1);
        @(negedge clk);
        req_valid[1] = 2'b10;
        @(posedge clk); #1;
        req_valid[1] = 2'b00;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("busy_before_reset", 16'(busy[1]), 16'(1));
        req_valid[1] = 2'b11;
        rst_n = 1'b0;
        #1;
        outputs_zero(1, "mid_exec_reset");
        last_m[0] = 1'b1;
        last_m[1] = 1'b1;
        @(negedge clk);
        req_valid[1] = 2'b00;
        rst_n = 1'b1;
        idle_check(1, lat + 3);
        rand_ops(1);
        do_op(1, 2'b11, 0, 1'b0, g);
        check("grant_after_reset", 16'(g), 16'(0));

        // Random traffic on both instances.
        for (int i = 0; i < 30; i++) begin
            int k;
            k = int'($urandom_range(0, 1));
            rand_ops(k);
            do_op(k, 2'($urandom_range(1, 3)), int'($urandom_range(0, 3)), 1'b0, g);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
